// File: rtl/dkongjr_pkg.sv
// rtl/dkongjr_pkg.sv - shared state type and constants for the object DMA
package dkongjr_pkg;

  localparam int OBJ_AW = 10;
  localparam int SRC_AW = 16;

  localparam logic [SRC_AW-1:0] SRC_BASE_DEF = 16'h6900;
  localparam logic [OBJ_AW-1:0] DST_BASE_DEF = 10'h000;
  localparam int                LEN_DEF      = 384;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    LAT,
    WR,
    REL
  } dma_state_t;

endpackage

// File: rtl/dkongjr_obj_dma_if.sv
// rtl/dkongjr_obj_dma_if.sv - Z80 bus grant, work-RAM read and object-RAM write port bundle
interface dkongjr_obj_dma_if;
  import dkongjr_pkg::*;

  logic              I_BUSAKn;
  logic [7:0]        I_SRC_DB;
  logic              O_BUSRQn;
  logic [SRC_AW-1:0] O_SRC_AB;
  logic              O_SRC_RDn;
  logic [OBJ_AW-1:0] O_OBJ_AB;
  logic [7:0]        O_OBJ_DB;
  logic              O_OBJ_WRn;
  logic              O_OBJ_RQn;

  modport master (
    input  I_BUSAKn, I_SRC_DB,
    output O_BUSRQn, O_SRC_AB, O_SRC_RDn, O_OBJ_AB, O_OBJ_DB, O_OBJ_WRn, O_OBJ_RQn
  );

  modport slave (
    output I_BUSAKn, I_SRC_DB,
    input  O_BUSRQn, O_SRC_AB, O_SRC_RDn, O_OBJ_AB, O_OBJ_DB, O_OBJ_WRn, O_OBJ_RQn
  );

endinterface

// File: rtl/dkongjr_obj_dma.sv
// rtl/dkongjr_obj_dma.sv - copies the sprite table from work RAM to object RAM under a Z80 bus grant
module dkongjr_obj_dma
  import dkongjr_pkg::*;
#(
  parameter logic [SRC_AW-1:0] SRC_BASE = SRC_BASE_DEF,
  parameter logic [OBJ_AW-1:0] DST_BASE = DST_BASE_DEF,
  parameter int                LEN      = LEN_DEF
) (
  input  logic               CLK_12M,
  input  logic               RST_4L,
  input  logic               I_START,
  dkongjr_obj_dma_if.master  bus,
  output logic               O_BUSY,
  output logic               O_DONE
);

  localparam logic [8:0] IDX_LAST = 9'(LEN - 1);

  dma_state_t        state_q, state_d;
  logic [8:0]        idx_q, idx_d;
  logic [7:0]        lat_q, lat_d;
  logic              busrqn_q, busrqn_d;
  logic              srcrdn_q, srcrdn_d;
  logic              objwrn_q, objwrn_d;
  logic              objrqn_q, objrqn_d;
  logic [SRC_AW-1:0] src_ab_q, src_ab_d;
  logic [OBJ_AW-1:0] obj_ab_q, obj_ab_d;
  logic [7:0]        obj_db_q, obj_db_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_xfer;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;

    case (state_q)
      IDLE: if (I_START) begin
        state_d = REQ;
        idx_d   = '0;
      end
      REQ: if (!bus.I_BUSAKn) state_d = RD;
      // Losing the grant mid-read retries the same byte after re-acquiring the bus.
      RD:  state_d = bus.I_BUSAKn ? REQ : LAT;
      LAT: begin
        lat_d   = bus.I_SRC_DB;
        state_d = WR;
      end
      WR: if (idx_q == IDX_LAST) begin
        state_d = REL;
      end else begin
        idx_d   = idx_q + 9'd1;
        state_d = RD;
      end
      REL: if (bus.I_BUSAKn) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    in_xfer  = (state_d == RD) || (state_d == LAT) || (state_d == WR);
    busrqn_d = !(in_xfer || (state_d == REQ));
    objrqn_d = !in_xfer;
    srcrdn_d = !((state_d == RD) || (state_d == LAT));
    objwrn_d = (state_d != WR);
    src_ab_d = SRC_BASE + {7'd0, idx_d};
    obj_ab_d = DST_BASE + {1'b0, idx_d};
    obj_db_d = lat_d;
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == REL) && (state_d == IDLE);
  end

  always_ff @(posedge CLK_12M or negedge RST_4L) begin
    if (!RST_4L) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      lat_q    <= '0;
      busrqn_q <= 1'b1;
      srcrdn_q <= 1'b1;
      objwrn_q <= 1'b1;
      objrqn_q <= 1'b1;
      src_ab_q <= SRC_BASE;
      obj_ab_q <= DST_BASE;
      obj_db_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      busrqn_q <= busrqn_d;
      srcrdn_q <= srcrdn_d;
      objwrn_q <= objwrn_d;
      objrqn_q <= objrqn_d;
      src_ab_q <= src_ab_d;
      obj_ab_q <= obj_ab_d;
      obj_db_q <= obj_db_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.O_BUSRQn  = busrqn_q;
  assign bus.O_SRC_AB  = src_ab_q;
  assign bus.O_SRC_RDn = srcrdn_q;
  assign bus.O_OBJ_AB  = obj_ab_q;
  assign bus.O_OBJ_DB  = obj_db_q;
  assign bus.O_OBJ_WRn = objwrn_q;
  assign bus.O_OBJ_RQn = objrqn_q;
  assign O_BUSY        = busy_q;
  assign O_DONE        = done_q;

endmodule

// File: tb/tb_dkongjr_obj_dma.sv
// tb/tb_dkongjr_obj_dma.sv - self-checking bench for the object DMA
module tb_dkongjr_obj_dma;

  localparam int          LEN = 384;
  localparam logic [15:0] SRC = 16'h6900;

  typedef struct {
    int ak_delay;
    int drop_idx;
    int drop_len;
    int restart_idx;
    int exp_cycles;
    int exp_writes;
    int exp_dones;
  } vec_t;

  typedef struct {
    logic [9:0] ab;
    logic [7:0] db;
  } wr_t;

  logic CLK_12M  = 1'b0;
  logic RST_4L   = 1'b0;
  logic I_START  = 1'b0;
  logic ak_block = 1'b0;
  logic O_BUSY, O_DONE;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  vec_t vecs[4];

  dkongjr_obj_dma_if bus();

  dkongjr_obj_dma #(
    .SRC_BASE(SRC),
    .DST_BASE(10'h000),
    .LEN(LEN)
  ) dut (
    .CLK_12M(CLK_12M),
    .RST_4L(RST_4L),
    .I_START(I_START),
    .bus(bus),
    .O_BUSY(O_BUSY),
    .O_DONE(O_DONE)
  );

  always #5 CLK_12M = ~CLK_12M;

  // Z80 acknowledges combinationally unless the bench is holding the grant off.
  assign bus.I_BUSAKn = bus.O_BUSRQn | ak_block;
  assign bus.I_SRC_DB = bus.O_SRC_RDn ? 8'h00 : (bus.O_SRC_AB[7:0] ^ 8'h5A);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input bit do_start, input bit rel_start,
                          output int cycles, output int writes, output int dones);
    wr_t         w;
    logic [15:0] sa;
    int          pre, drop_left;
    bit          rel_next, dropped, prev_rdn, fin;
    for (int i = 0; i < LEN; i++) begin
      sa   = SRC + 16'(i);
      w.ab = 10'(i);
      w.db = sa[7:0] ^ 8'h5A;
      exp_q.push_back(w);
    end
    cycles = 0; writes = 0; dones = 0;
    pre = v.ak_delay; drop_left = 0;
    rel_next = 0; dropped = 0; prev_rdn = 1; fin = 0;
    if (do_start) begin
      ak_block = (v.ak_delay > 0);
      @(negedge CLK_12M); I_START = 1'b1;
      @(negedge CLK_12M); I_START = 1'b0;
    end
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (!rel_start) I_START = 1'b0;
      if (O_BUSY) cycles++;
      if (!bus.O_OBJ_WRn) begin
        writes++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_extra_write: actual addr=0x%0h expected no write", bus.O_OBJ_AB);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", 32'(bus.O_OBJ_AB), 32'(w.ab));
          chk("wr_data", 32'(bus.O_OBJ_DB), 32'(w.db));
        end
        chk("wr_rd_overlap", 32'(bus.O_SRC_RDn), 1);
        chk("wr_rq_low", 32'(bus.O_OBJ_RQn), 0);
        if (v.restart_idx >= 0 && bus.O_OBJ_AB == 10'(v.restart_idx)) I_START = 1'b1;
      end
      if (O_DONE) begin
        dones++;
        fin = 1;
      end
      if (pre > 0) begin
        chk("pre_grant_rdn", 32'(bus.O_SRC_RDn), 1);
        chk("pre_grant_wrn", 32'(bus.O_OBJ_WRn), 1);
        pre--;
        if (pre == 0) rel_next = 1;
      end else if (rel_next) begin
        ak_block = 1'b0;
        rel_next = 0;
      end
      if (v.drop_idx >= 0 && !dropped && !bus.O_SRC_RDn && prev_rdn &&
          bus.O_SRC_AB == SRC + 16'(v.drop_idx)) begin
        ak_block  = 1'b1;
        drop_left = v.drop_len;
        dropped   = 1;
      end else if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) ak_block = 1'b0;
      end
      if (rel_start && O_BUSY && bus.O_BUSRQn) I_START = 1'b1;
      prev_rdn = bus.O_SRC_RDn;
      if (!fin) @(negedge CLK_12M);
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: actual no O_DONE within 3000 cycles, required O_DONE");
    end
    chk("sb_leftover", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int cy, wr, dn;
    bit found;

    vecs[0] = '{0, -1, 0, -1, 1154, 384, 1};
    vecs[1] = '{7, -1, 0, -1, 1161, 384, 1};
    vecs[2] = '{0, 100, 4, -1, 1159, 384, 1};
    vecs[3] = '{0, -1, 0, 50, 1154, 384, 1};

    RST_4L = 1'b0;
    repeat (5) @(negedge CLK_12M);
    chk("rst_strobes", 32'({bus.O_BUSRQn, bus.O_SRC_RDn, bus.O_OBJ_WRn, bus.O_OBJ_RQn, O_BUSY, O_DONE}), 32'h3C);
    RST_4L = 1'b1;
    repeat (4) begin
      @(negedge CLK_12M);
      chk("idle_strobes", 32'({bus.O_BUSRQn, bus.O_SRC_RDn, bus.O_OBJ_WRn, bus.O_OBJ_RQn, O_BUSY, O_DONE}), 32'h3C);
      chk("idle_src_ab", 32'(bus.O_SRC_AB), 32'h6900);
      chk("idle_obj_ab", 32'(bus.O_OBJ_AB), 0);
      chk("idle_obj_db", 32'(bus.O_OBJ_DB), 0);
    end

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i], 1'b1, 1'b0, cy, wr, dn);
      chk($sformatf("v%0d_cycles", i), cy, vecs[i].exp_cycles);
      chk($sformatf("v%0d_writes", i), wr, vecs[i].exp_writes);
      chk($sformatf("v%0d_dones", i), dn, vecs[i].exp_dones);
      repeat (2) begin
        @(negedge CLK_12M);
        chk($sformatf("v%0d_post_idle", i), 32'({O_BUSY, O_DONE, bus.O_BUSRQn}), 32'h1);
      end
    end

    // START held across the REL->IDLE edge: first sample ignored, second accepted.
    run_xfer(vecs[0], 1'b1, 1'b1, cy, wr, dn);
    chk("bnd_dones", dn, 1);
    chk("bnd_ignored_busy", 32'(O_BUSY), 0);
    @(negedge CLK_12M);
    chk("bnd_accept_busy", 32'(O_BUSY), 1);
    I_START = 1'b0;
    run_xfer(vecs[0], 1'b0, 1'b0, cy, wr, dn);
    chk("bnd2_cycles", cy, 1154);
    chk("bnd2_writes", wr, 384);
    chk("bnd2_dones", dn, 1);

    // Asynchronous reset during the write of idx 200, then a fresh transfer.
    @(negedge CLK_12M); I_START = 1'b1;
    @(negedge CLK_12M); I_START = 1'b0;
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (!bus.O_OBJ_WRn && bus.O_OBJ_AB == 10'd200) found = 1;
      else @(negedge CLK_12M);
    end
    chk("midrst_reach_idx200", 32'(found), 1);
    RST_4L = 1'b0;
    @(negedge CLK_12M);
    chk("midrst_wrn", 32'(bus.O_OBJ_WRn), 1);
    chk("midrst_busrqn", 32'(bus.O_BUSRQn), 1);
    chk("midrst_busy", 32'(O_BUSY), 0);
    chk("midrst_done", 32'(O_DONE), 0);
    RST_4L = 1'b1;
    @(negedge CLK_12M);
    run_xfer(vecs[0], 1'b1, 1'b0, cy, wr, dn);
    chk("rst_restart_cycles", cy, 1154);
    chk("rst_restart_writes", wr, 384);
    chk("rst_restart_dones", dn, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
